mem_bus_arbiter: RTL

- Shares one single-port memory bus between the instruction fetch port and the data load/store port of the pipeline.
- Sequences each access: grant, hold the request until acknowledge, then return the response to the granted requester.
- Handles fetch flushes by draining the in-flight instruction read and discarding its data.
- Sits between the core (IF and MEM stages) and the memory/interconnect.

---
 rtl/mem_bus_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and load/store.
// Optional bus timeout with abort and error pulse: MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter #(
   parameter int unsigned ADDR_WIDTH      = 32,
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned MAX_DATA_STREAK = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  instruction_request_i,
   input  logic [ADDR_WIDTH-1:0] instruction_addr_i,
   input  logic                  flush_bus_i,
   output logic                  instruction_response_o,
   output logic [DATA_WIDTH-1:0] instruction_data_o,
   input  logic                  data_read_request_i,
   input  logic                  data_write_request_i,
   input  logic [ADDR_WIDTH-1:0] data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_write_data_i,
   input  logic [3:0]            data_byte_enable_i,
   output logic                  data_response_o,
   output logic [DATA_WIDTH-1:0] data_read_data_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_write_data_o,
   output logic [3:0]            mem_byte_enable_o,
   input  logic                  mem_ack_i,
   input  logic [DATA_WIDTH-1:0] mem_read_data_i,
   output logic                  bus_error_o
);

   localparam int unsigned SW =
      (MAX_DATA_STREAK > 0) ? $clog2(MAX_DATA_STREAK + 1) : 1;
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DATA_STREAK);

   typedef enum logic [1:0] {
      IDLE,
      INSTR,
      DATA,
      DRAIN
   } state_e;

   state_e                state_q, state_d;
   logic [SW-1:0]         streak_q, streak_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_be_q, mem_be_d;
   logic                  instr_rsp_q, instr_rsp_d;
   logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
   logic                  data_rsp_q, data_rsp_d;
   logic [DATA_WIDTH-1:0] data_rdata_q, data_rdata_d;

   logic data_req;
   logic instr_ok;
   logic fetch_prio;
   logic grant_data;
   logic grant_instr;
   logic timeout;

   // A flushed fetch is not a candidate, so it cannot block a waiting load/store.
   assign data_req    = data_read_request_i | data_write_request_i;
   assign instr_ok    = instruction_request_i & ~flush_bus_i;
   assign fetch_prio  = instr_ok && (MAX_DATA_STREAK != 0)
                        && (streak_q == STREAK_MAX);
   assign grant_data  = (state_q == IDLE) && data_req && !fetch_prio;
   assign grant_instr = (state_q == IDLE) && instr_ok && !grant_data;

   always_comb begin
      streak_d = streak_q;
      if (!instruction_request_i || grant_instr) begin
         streak_d = '0;
      end else if (grant_data && (streak_q != STREAK_MAX)) begin
         streak_d = streak_q + 1'b1;
      end
   end

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          bus_error_q, bus_error_d;

   assign timeout = (state_q != IDLE) && !mem_ack_i
                    && (to_cnt_q == TO_LAST);

   always_comb begin
      to_cnt_d    = to_cnt_q + 1'b1;
      bus_error_d = timeout;
      if ((state_q == IDLE) || mem_ack_i || timeout) begin
         to_cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt_q    <= '0;
         bus_error_q <= 1'b0;
      end else begin
         to_cnt_q    <= to_cnt_d;
         bus_error_q <= bus_error_d;
      end
   end

   assign bus_error_o = bus_error_q;
`else
   assign timeout     = 1'b0;
   assign bus_error_o = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      mem_read_d   = mem_read_q;
      mem_write_d  = mem_write_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_be_d     = mem_be_q;
      instr_rsp_d  = 1'b0;
      instr_data_d = instr_data_q;
      data_rsp_d   = 1'b0;
      data_rdata_d = data_rdata_q;

      unique case (state_q)
         IDLE: begin
            if (grant_data) begin
               state_d    = DATA;
               mem_addr_d = data_addr_i;
               if (data_write_request_i) begin
                  mem_write_d = 1'b1;
                  mem_wdata_d = data_write_data_i;
                  mem_be_d    = data_byte_enable_i;
               end else begin
                  mem_read_d  = 1'b1;
                  mem_wdata_d = '0;
                  mem_be_d    = 4'hF;
               end
            end else if (grant_instr) begin
               state_d     = INSTR;
               mem_read_d  = 1'b1;
               mem_addr_d  = instruction_addr_i;
               mem_wdata_d = '0;
               mem_be_d    = 4'hF;
            end
         end

         INSTR: begin
            if (mem_ack_i || timeout) begin
               state_d    = IDLE;
               mem_read_d = 1'b0;
               if (!flush_bus_i) begin
                  instr_rsp_d  = 1'b1;
                  instr_data_d = mem_ack_i ? mem_read_data_i : '0;
               end
            end else if (flush_bus_i) begin
               state_d = DRAIN;
            end
         end

         DATA: begin
            if (mem_ack_i) begin
               state_d     = IDLE;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               data_rsp_d  = 1'b1;
               if (mem_read_q) begin
                  data_rdata_d = mem_read_data_i;
               end
            end else if (timeout) begin
               state_d      = IDLE;
               mem_read_d   = 1'b0;
               mem_write_d  = 1'b0;
               data_rsp_d   = 1'b1;
               data_rdata_d = '0;
            end
         end

         DRAIN: begin
            // Abandoned fetch: wait out the bus, throw the word away.
            if (mem_ack_i || timeout) begin
               state_d    = IDLE;
               mem_read_d = 1'b0;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         streak_q     <= '0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_be_q     <= 4'h0;
         instr_rsp_q  <= 1'b0;
         instr_data_q <= '0;
         data_rsp_q   <= 1'b0;
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         streak_q     <= streak_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_be_q     <= mem_be_d;
         instr_rsp_q  <= instr_rsp_d;
         instr_data_q <= instr_data_d;
         data_rsp_q   <= data_rsp_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   assign mem_read_o             = mem_read_q;
   assign mem_write_o            = mem_write_q;
   assign mem_addr_o             = mem_addr_q;
   assign mem_write_data_o       = mem_wdata_q;
   assign mem_byte_enable_o      = mem_be_q;
   assign instruction_response_o = instr_rsp_q;
   assign instruction_data_o     = instr_data_q;
   assign data_response_o        = data_rsp_q;
   assign data_read_data_o       = data_rdata_q;

endmodule
